reg_cmd_decoder: RTL



---
 rtl/reg_cmd_pkg.sv | 17 +
 rtl/idle_timer.sv | 30 +++
 rtl/reg_cmd_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the PC-link register command decoder.
// The state encoding lives here so other blocks can decode the FSM state if needed.
package reg_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_WRITE,
    ST_TX_DATA
  } state_e;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_BITS     = 7;

  localparam logic [7:0] ZERO_RESP = 8'h00;

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle counter with synchronous clear, count enable and terminal pulse.
// Used by reg_cmd_decoder only when REG_CMD_TIMEOUT_EN is defined.
module idle_timer #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the LIMIT-th consecutive enabled cycle without a clear.
  assign o_done = i_en & ~i_clr & (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/reg_cmd_decoder.sv
// Byte-stream write/read command decoder for the signal register bank.
// Optional inter-byte write timeout is enabled with REG_CMD_TIMEOUT_EN.
module reg_cmd_decoder
  import reg_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REGS-1:0]           reg_write,
  output logic [DATA_BITS-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_BITS-1:0] reg_rdata,
  output logic                          busy,
  output logic                          err_pulse
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  state_e                 r_state;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_oor;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_wdata;
  logic [NUM_REGS-1:0]    r_write;
  logic                   r_tx_valid;

  logic                   w_cmd_wr;
  logic [ADDR_BITS-1:0]   w_cmd_addr;
  logic                   w_cmd_oor;
  logic [DATA_BITS-1:0]   w_rd_word;
  logic [DATA_BITS-1:0]   w_shift_in;
  logic [NUM_REGS-1:0]    w_onehot;
  logic                   w_last;
  logic                   w_hs;
  logic                   w_timeout;
  logic                   w_in_rx;
  logic                   w_in_wr;
  logic                   w_in_tx;
  logic                   w_in_idle;

  assign w_cmd_wr   = rx_data[CMD_WRITE_BIT];
  assign w_cmd_addr = rx_data[ADDR_BITS-1:0];
  assign w_cmd_oor  = ({1'b0, w_cmd_addr} >= 8'(NUM_REGS));
  assign w_shift_in = (r_shift << 8) | DATA_BITS'(rx_data);
  assign w_last     = (r_cnt == CNT_W'(NBYTES - 1));
  assign w_hs       = r_tx_valid & tx_ready;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_rx    = (r_state == ST_RX_DATA);
  assign w_in_wr    = (r_state == ST_WRITE);
  assign w_in_tx    = (r_state == ST_TX_DATA);

  // Unmapped addresses read back as all-zero bytes.
  always_comb begin
    w_rd_word = {NBYTES{ZERO_RESP}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_cmd_addr == ADDR_BITS'(i)) begin
        w_rd_word = reg_rdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == ADDR_BITS'(i)) begin
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef REG_CMD_TIMEOUT_EN
  idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_clr  (rx_valid | ~w_in_rx),
    .i_en   (w_in_rx),
    .o_done (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_oor      <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_wdata    <= '0;
      r_write    <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            r_cnt <= '0;
            if (w_cmd_wr) begin
              r_addr  <= w_cmd_addr;
              r_oor   <= w_cmd_oor;
              r_state <= ST_RX_DATA;
            end else begin
              r_shift    <= w_rd_word;
              r_tx_valid <= 1'b1;
              r_state    <= ST_TX_DATA;
            end
          end
        end
        ST_RX_DATA: begin
          if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (rx_valid) begin
            r_shift <= w_shift_in;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_WRITE;
              if (!r_oor) begin
                r_write <= w_onehot;
                r_wdata <= w_shift_in;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_write <= '0;
          r_state <= ST_IDLE;
        end
        ST_TX_DATA: begin
          if (w_hs) begin
            r_shift <= r_shift << 8;
            if (w_last) begin
              r_cnt      <= '0;
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_write    <= '0;
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // All error sources OR into one pulse so coincident events give one pulse.
  assign err_pulse = (rx_valid & w_in_idle & ~w_cmd_wr & w_cmd_oor)
                   | (rx_valid & (w_in_wr | w_in_tx))
                   | (w_in_wr & r_oor)
                   | w_timeout;

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_valid ? r_shift[DATA_BITS-1 -: 8] : 8'h00;
  assign reg_write = r_write;
  assign reg_wdata = r_wdata;
  assign busy      = ~w_in_idle;

endmodule
